// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller for the five-stage DLX core.
// Decides IF/ID advance/stall/flush and EX hold each cycle, drives the EX
// operand forwarding selects, and keeps stall/flush performance counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// RUN      | normal issue; load-use stalls, branch flushes, multiply entry
// MUL_BUSY | multi-cycle op occupies EX; cnt counts remaining hold cycles
module pipe_ctrl #(
  parameter int unsigned MUL_LATENCY = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_ID,
  input  logic [4:0]  Rs1_ID,
  input  logic [4:0]  Rs2_ID,
  input  logic        uses_rs1_ID,
  input  logic        uses_rs2_ID,
  input  logic [4:0]  Rs1_EX,
  input  logic [4:0]  Rs2_EX,
  input  logic [4:0]  Rd_EX,
  input  logic        d_load_enable_EX,
  input  logic        mul_EX,
  input  logic        pc_cmd_EX,
  input  logic [4:0]  Rd_MEM,
  input  logic        reg_write_MEM,
  input  logic [4:0]  Rd_WB,
  input  logic        reg_write_WB,
  input  logic        clr_cnt,
  output logic        stall_IF,
  output logic        stall_ID,
  output logic        bubble_EX,
  output logic        flush_ID,
  output logic        hold_EX,
  output logic [1:0]  fwd_s1_sel,
  output logic [1:0]  fwd_s2_sel,
  output logic [31:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  typedef enum logic {RUN, MUL_BUSY} state_t;

  // The entry cycle is already one hold cycle, so the busy phase needs L-2 more.
  localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LATENCY - 2);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu;

  // Load-use hazard: ID reads a non-zero register that the EX load writes.
  always_comb begin
    lu = d_load_enable_EX && (Rd_EX != 5'd0) && valid_ID &&
         ((uses_rs1_ID && (Rs1_ID == Rd_EX)) || (uses_rs2_ID && (Rs2_ID == Rd_EX)));
  end

  // State and hold-counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RUN;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state and control outputs; multiply beats branch beats load-use.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall_IF  = 1'b0;
    stall_ID  = 1'b0;
    bubble_EX = 1'b0;
    flush_ID  = 1'b0;
    hold_EX   = 1'b0;
    case (state_q)
      RUN: begin
        if (mul_EX) begin
          hold_EX  = 1'b1;
          stall_IF = 1'b1;
          stall_ID = 1'b1;
          cnt_d    = MUL_CNT_INIT;
          state_d  = MUL_BUSY;
        end else if (pc_cmd_EX) begin
          flush_ID  = 1'b1;
          bubble_EX = 1'b1;
        end else if (lu) begin
          stall_IF  = 1'b1;
          stall_ID  = 1'b1;
          bubble_EX = 1'b1;
        end
      end
      MUL_BUSY: begin
        // Branches and load-use are ignored here; lu is re-examined in RUN.
        if (cnt_q != 4'd0) begin
          hold_EX  = 1'b1;
          stall_IF = 1'b1;
          stall_ID = 1'b1;
          cnt_d    = cnt_q - 4'd1;
        end else begin
          state_d = RUN;
        end
      end
      default: state_d = RUN;
    endcase
  end

  // Forwarding selects: MEM result wins over WB data; r0 never forwards.
  always_comb begin
    fwd_s1_sel = 2'b00;
    fwd_s2_sel = 2'b00;
    if (reg_write_MEM && (Rd_MEM == Rs1_EX) && (Rs1_EX != 5'd0))
      fwd_s1_sel = 2'b01;
    else if (reg_write_WB && (Rd_WB == Rs1_EX) && (Rs1_EX != 5'd0))
      fwd_s1_sel = 2'b10;
    if (reg_write_MEM && (Rd_MEM == Rs2_EX) && (Rs2_EX != 5'd0))
      fwd_s2_sel = 2'b01;
    else if (reg_write_WB && (Rd_WB == Rs2_EX) && (Rs2_EX != 5'd0))
      fwd_s2_sel = 2'b10;
  end

  // Performance counters; clear overrides any increment in the same cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 16'd0;
    end else if (clr_cnt) begin
      stall_cnt <= 32'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall_IF)
        stall_cnt <= stall_cnt + 32'd1;
      if (flush_ID && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed testbench for pipe_ctrl (MUL_LATENCY = 4).
// Inputs change on the falling edge; combinational outputs are sampled 1ns
// later, counters are sampled 1ns after the rising edge.
module tb_pipe_ctrl;

  logic        clk;
  logic        reset_n;
  logic        valid_ID;
  logic [4:0]  Rs1_ID, Rs2_ID;
  logic        uses_rs1_ID, uses_rs2_ID;
  logic [4:0]  Rs1_EX, Rs2_EX, Rd_EX;
  logic        d_load_enable_EX, mul_EX, pc_cmd_EX;
  logic [4:0]  Rd_MEM, Rd_WB;
  logic        reg_write_MEM, reg_write_WB;
  logic        clr_cnt;
  logic        stall_IF, stall_ID, bubble_EX, flush_ID, hold_EX;
  logic [1:0]  fwd_s1_sel, fwd_s2_sel;
  logic [31:0] stall_cnt;
  logic [15:0] flush_cnt;

  int n_checks;
  int n_fail;

  pipe_ctrl #(.MUL_LATENCY(4)) dut (
    .clk(clk), .reset_n(reset_n), .valid_ID(valid_ID),
    .Rs1_ID(Rs1_ID), .Rs2_ID(Rs2_ID),
    .uses_rs1_ID(uses_rs1_ID), .uses_rs2_ID(uses_rs2_ID),
    .Rs1_EX(Rs1_EX), .Rs2_EX(Rs2_EX), .Rd_EX(Rd_EX),
    .d_load_enable_EX(d_load_enable_EX), .mul_EX(mul_EX), .pc_cmd_EX(pc_cmd_EX),
    .Rd_MEM(Rd_MEM), .reg_write_MEM(reg_write_MEM),
    .Rd_WB(Rd_WB), .reg_write_WB(reg_write_WB), .clr_cnt(clr_cnt),
    .stall_IF(stall_IF), .stall_ID(stall_ID), .bubble_EX(bubble_EX),
    .flush_ID(flush_ID), .hold_EX(hold_EX),
    .fwd_s1_sel(fwd_s1_sel), .fwd_s2_sel(fwd_s2_sel),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    valid_ID = 0; Rs1_ID = 0; Rs2_ID = 0; uses_rs1_ID = 0; uses_rs2_ID = 0;
    Rs1_EX = 0; Rs2_EX = 0; Rd_EX = 0; d_load_enable_EX = 0; mul_EX = 0;
    pc_cmd_EX = 0; Rd_MEM = 0; reg_write_MEM = 0; Rd_WB = 0; reg_write_WB = 0;
    clr_cnt = 0;
  endtask

  task automatic set_lu_r5();
    d_load_enable_EX = 1; Rd_EX = 5; valid_ID = 1; uses_rs1_ID = 1; Rs1_ID = 5;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 0;
    #2;
    reset_n = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    idle_inputs();
    reset_n = 0;
    #1;
    n_checks++;
    if ({stall_IF, stall_ID, bubble_EX, flush_ID, hold_EX, fwd_s1_sel, fwd_s2_sel} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b expected 0", {stall_IF, stall_ID, bubble_EX, flush_ID, hold_EX, fwd_s1_sel, fwd_s2_sel});
    end
    n_checks++;
    if (stall_cnt !== 32'd0 || flush_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_cnt: got stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt);
    end
    reset_n = 1;
  endtask

  task automatic test_load_use();
    apply_reset();
    @(negedge clk);
    set_lu_r5();
    #1;
    n_checks++;
    if ({stall_IF, stall_ID, bubble_EX, flush_ID, hold_EX} !== 5'b11100) begin
      n_fail++;
      $display("FAIL lu_stall: got %b expected 11100", {stall_IF, stall_ID, bubble_EX, flush_ID, hold_EX});
    end
    @(posedge clk); #1;
    n_checks++;
    if (stall_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL lu_stall_cnt: got %0d expected 1", stall_cnt);
    end
    @(negedge clk);
    idle_inputs();
    Rs1_EX = 5; Rd_WB = 5; reg_write_WB = 1; valid_ID = 1; Rs1_ID = 6; uses_rs1_ID = 1;
    #1;
    n_checks++;
    if (fwd_s1_sel !== 2'b10 || stall_IF !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_fwd: got fwd=%b stall=%b expected 10/0", fwd_s1_sel, stall_IF);
    end
    @(negedge clk);
    idle_inputs();
    d_load_enable_EX = 1; Rd_EX = 0; valid_ID = 1; uses_rs1_ID = 1; Rs1_ID = 0;
    #1;
    n_checks++;
    if ({stall_IF, bubble_EX} !== 2'b00) begin
      n_fail++;
      $display("FAIL lu_r0: got %b expected 00", {stall_IF, bubble_EX});
    end
    @(negedge clk);
    idle_inputs();
    d_load_enable_EX = 1; Rd_EX = 9; valid_ID = 1; uses_rs2_ID = 1; Rs2_ID = 9; Rs1_ID = 9;
    #1;
    n_checks++;
    if ({stall_IF, stall_ID, bubble_EX} !== 3'b111) begin
      n_fail++;
      $display("FAIL lu_rs2: got %b expected 111", {stall_IF, stall_ID, bubble_EX});
    end
    uses_rs2_ID = 0;
    #1;
    n_checks++;
    if (stall_IF !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_unused_src: got %b expected 0", stall_IF);
    end
    uses_rs2_ID = 1; valid_ID = 0;
    #1;
    n_checks++;
    if (stall_IF !== 1'b0) begin
      n_fail++;
      $display("FAIL lu_invalid_id: got %b expected 0", stall_IF);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_forwarding();
    @(negedge clk);
    idle_inputs();
    Rs2_EX = 7; Rd_MEM = 7; Rd_WB = 7; reg_write_MEM = 1; reg_write_WB = 1;
    #1;
    n_checks++;
    if (fwd_s2_sel !== 2'b01) begin
      n_fail++;
      $display("FAIL fwd_mem_prio: got %b expected 01", fwd_s2_sel);
    end
    reg_write_MEM = 0;
    #1;
    n_checks++;
    if (fwd_s2_sel !== 2'b10) begin
      n_fail++;
      $display("FAIL fwd_wb: got %b expected 10", fwd_s2_sel);
    end
    reg_write_WB = 0;
    #1;
    n_checks++;
    if (fwd_s2_sel !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_none: got %b expected 00", fwd_s2_sel);
    end
    Rs2_EX = 0; Rd_MEM = 0; Rd_WB = 0; reg_write_MEM = 1; reg_write_WB = 1;
    Rs1_EX = 3;
    #1;
    n_checks++;
    if (fwd_s2_sel !== 2'b00 || fwd_s1_sel !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_r0: got s1=%b s2=%b expected 00/00", fwd_s1_sel, fwd_s2_sel);
    end
    Rd_MEM = 3;
    #1;
    n_checks++;
    if (fwd_s1_sel !== 2'b01 || fwd_s2_sel !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_s1_mem: got s1=%b s2=%b expected 01/00", fwd_s1_sel, fwd_s2_sel);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_multiply();
    apply_reset();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      idle_inputs();
      mul_EX = 1;
      set_lu_r5();
      if (c == 2) pc_cmd_EX = 1;
      #1;
      n_checks++;
      if ({hold_EX, stall_IF, stall_ID, bubble_EX, flush_ID} !== ((c < 3) ? 5'b11100 : 5'b00000)) begin
        n_fail++;
        $display("FAIL mul_cycle%0d: got %b expected %b", c, {hold_EX, stall_IF, stall_ID, bubble_EX, flush_ID},
                 (c < 3) ? 5'b11100 : 5'b00000);
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (stall_cnt !== 32'd3 || flush_cnt !== 16'd0) begin
      n_fail++;
      $display("FAIL mul_counts: got stall=%0d flush=%0d expected 3/0", stall_cnt, flush_cnt);
    end
  endtask

  task automatic test_back_to_back();
    apply_reset();
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      idle_inputs();
      mul_EX = 1;
      #1;
      n_checks++;
      if (hold_EX !== ((c % 4) != 3)) begin
        n_fail++;
        $display("FAIL b2b_hold_c%0d: got %b expected %b", c, hold_EX, ((c % 4) != 3));
      end
    end
    @(negedge clk);
    idle_inputs();
    #1;
    n_checks++;
    if (stall_cnt !== 32'd6 || hold_EX !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: got stall_cnt=%0d hold=%b expected 6/0", stall_cnt, hold_EX);
    end
  endtask

  task automatic test_branch();
    apply_reset();
    @(negedge clk);
    set_lu_r5();
    pc_cmd_EX = 1;
    #1;
    n_checks++;
    if ({flush_ID, bubble_EX, stall_IF, stall_ID, hold_EX} !== 5'b11000) begin
      n_fail++;
      $display("FAIL branch_lu: got %b expected 11000", {flush_ID, bubble_EX, stall_IF, stall_ID, hold_EX});
    end
    @(posedge clk); #1;
    n_checks++;
    if (flush_cnt !== 16'd1 || stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL branch_cnt: got flush=%0d stall=%0d expected 1/0", flush_cnt, stall_cnt);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_flush_saturate();
    apply_reset();
    @(negedge clk);
    pc_cmd_EX = 1;
    repeat (65535) @(posedge clk);
    #1;
    n_checks++;
    if (flush_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL flush_reach_max: got %h expected ffff", flush_cnt);
    end
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (flush_cnt !== 16'hFFFF) begin
      n_fail++;
      $display("FAIL flush_saturate: got %h expected ffff", flush_cnt);
    end
    @(negedge clk);
    clr_cnt = 1;
    @(posedge clk); #1;
    n_checks++;
    if (flush_cnt !== 16'h0000) begin
      n_fail++;
      $display("FAIL flush_clr_over_inc: got %h expected 0000", flush_cnt);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_reset_during_mul();
    apply_reset();
    @(negedge clk);
    mul_EX = 1;
    @(negedge clk);
    #1;
    n_checks++;
    if (hold_EX !== 1'b1 || stall_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL rmul_pre: got hold=%b stall_cnt=%0d expected 1/1", hold_EX, stall_cnt);
    end
    mul_EX = 0;
    reset_n = 0;
    #1;
    n_checks++;
    if ({hold_EX, stall_IF, stall_ID, bubble_EX, flush_ID} !== 5'b00000 || stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL rmul_async: got %b stall_cnt=%0d expected 00000/0",
               {hold_EX, stall_IF, stall_ID, bubble_EX, flush_ID}, stall_cnt);
    end
    @(negedge clk);
    reset_n = 1;
    #1;
    n_checks++;
    if ({hold_EX, stall_IF} !== 2'b00) begin
      n_fail++;
      $display("FAIL rmul_run_idle: got %b expected 00", {hold_EX, stall_IF});
    end
    @(negedge clk);
    set_lu_r5();
    #1;
    n_checks++;
    if ({stall_IF, bubble_EX, hold_EX} !== 3'b110) begin
      n_fail++;
      $display("FAIL rmul_run_lu: got %b expected 110", {stall_IF, bubble_EX, hold_EX});
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_clr_cnt();
    apply_reset();
    @(negedge clk);
    set_lu_r5();
    @(posedge clk); #1;
    n_checks++;
    if (stall_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL clr_pre: got %0d expected 1", stall_cnt);
    end
    @(negedge clk);
    clr_cnt = 1;
    @(posedge clk); #1;
    n_checks++;
    if (stall_cnt !== 32'd0) begin
      n_fail++;
      $display("FAIL clr_with_stall: got %0d expected 0", stall_cnt);
    end
    @(negedge clk);
    clr_cnt = 0;
    @(posedge clk); #1;
    n_checks++;
    if (stall_cnt !== 32'd1) begin
      n_fail++;
      $display("FAIL clr_resume: got %0d expected 1", stall_cnt);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    idle_inputs();
    reset_n = 0;
    #12;
    reset_n = 1;
    test_reset();
    test_load_use();
    test_forwarding();
    test_multiply();
    test_back_to_back();
    test_branch();
    test_reset_during_mul();
    test_clr_cnt();
    test_flush_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline sequencing controller for the five-stage DLX core. It decides each cycle whether IF/ID advance, stall or flush, and whether EX is held. It handles load-use hazards, taken-branch flushes from EX, and multi-cycle ALU operations (multiply) occupying EX. It also drives operand-forwarding selects for the EX input muxes and keeps stall/flush performance counters.

## Interface
Parameters:
- MUL_LATENCY, 4: total cycles a multi-cycle op occupies EX; legal range 2..16.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- valid_ID  in  1  ID holds a real instruction
- Rs1_ID, Rs2_ID  in  5  source registers of instruction in ID
- uses_rs1_ID, uses_rs2_ID  in  1  ID instruction reads that source
- Rs1_EX, Rs2_EX  in  5  source registers of instruction in EX
- Rd_EX  in  5  destination of EX instruction
- d_load_enable_EX  in  1  EX instruction is a load
- mul_EX  in  1  EX instruction is multi-cycle
- pc_cmd_EX  in  1  taken control transfer resolved in EX
- Rd_MEM, reg_write_MEM  in  5, 1  MEM-stage destination and write flag
- Rd_WB, reg_write_WB  in  5, 1  WB-stage destination and write flag
- clr_cnt  in  1  synchronous clear of both counters
- stall_IF  out  1  hold PC and IF/ID register
- stall_ID  out  1  hold ID/EX inputs (ID instruction stays)
- bubble_EX  out  1  load NOP into ID/EX register
- flush_ID  out  1  kill instructions in IF/ID (write NOP)
- hold_EX  out  1  hold EX operands; suppress EX/MEM update (bubble into MEM)
- fwd_s1_sel, fwd_s2_sel  out  2  00 register file, 01 MEM ALU result, 10 WB data
- stall_cnt  out  32  cycles with stall_IF=1, wraps
- flush_cnt  out  16  flush events, saturates at 16'hFFFF

## Operation
- State machine: RUN, MUL_BUSY. Down-counter cnt[3:0].
- Register 0 is never a hazard or a forwarding source.
- Load-use hazard (lu): d_load_enable_EX & Rd_EX!=0 & valid_ID & ((uses_rs1_ID & Rs1_ID==Rd_EX) | (uses_rs2_ID & Rs2_ID==Rd_EX)).
- RUN:
  - mul_EX=1: hold_EX=stall_IF=stall_ID=1. cnt<=MUL_LATENCY-2. Next state MUL_BUSY.
  - Else pc_cmd_EX=1: flush_ID=1 and bubble_EX=1. No stall. flush_cnt increments. Flush has priority over lu.
  - Else lu: stall_IF=stall_ID=bubble_EX=1.
- MUL_BUSY:
  - cnt!=0: hold_EX=stall_IF=stall_ID=1, cnt decrements.
  - cnt==0: all stall/hold outputs 0. The op completes into MEM. Next state RUN.
  - pc_cmd_EX and lu are ignored in this state. lu is re-evaluated once back in RUN.
- Forwarding, per operand: MEM match (reg_write_MEM & Rd_MEM==Rs_EX & Rs_EX!=0) selects 01. Else the same test on WB selects 10. Else 00. MEM wins when both match.
- Counters:
  - stall_cnt +1 every cycle stall_IF=1, modulo 2^32.
  - flush_cnt saturates.
  - clr_cnt clears both on the next edge; a clear overrides an increment in the same cycle.
- Control outputs are combinational from state, cnt and inputs. Counters are registered.

## Timing
- Reset (async, immediate): state RUN, cnt 0, stall_cnt 0, flush_cnt 0. With inputs at 0 every output is 0.
- Reset during MUL_BUSY drops hold_EX/stall_* immediately and returns to RUN.
- Load-use costs exactly one bubble. The loaded value reaches the dependent instruction through fwd 10 on the following cycle.
- A multiply entering EX at cycle t holds EX for cycles t..t+MUL_LATENCY-2. It advances at the edge ending t+MUL_LATENCY-1.
- A taken branch costs 2 killed slots (IF/ID and ID/EX) and no stall cycle.
- Back-to-back multiplies: the second enters EX at t+MUL_LATENCY and starts a fresh sequence from RUN.

## Test plan
- Load-use: load r5 in EX, ID reads r5 (uses_rs1_ID=1) -> stall_IF=stall_ID=bubble_EX=1 for 1 cycle, stall_cnt=1. Next cycle Rs1_EX=5, Rd_WB=5 -> fwd_s1_sel=10. Same case with Rd_EX=0 -> no stall.
- Forwarding priority: Rs2_EX=7, Rd_MEM=7, Rd_WB=7, both write flags 1 -> fwd_s2_sel=01. With reg_write_MEM=0 -> 10.
- Multiply, MUL_LATENCY=4: mul_EX at cycle 0 -> hold_EX=1 in cycles 0,1,2 and 0 in cycle 3. stall_cnt=3. A load-use present in ID produces no bubble_EX during the hold.
- Taken branch with simultaneous lu -> flush_ID=bubble_EX=1, stall_IF=0, flush_cnt +1. Preload flush_cnt to FFFF -> stays FFFF.
- reset_n low in cycle 1 of a multiply -> outputs 0 asynchronously, counters 0. After release, mul_EX=0 -> normal RUN.
- clr_cnt high together with a stall cycle -> stall_cnt=0 next cycle.
